// File: rtl/otter_lsu_pkg.sv
// -----------------------------------------------------------------------------
// otter_lsu_pkg
// Shared definitions for the OTTER load/store unit:
//   - lsu_state_t     : LSU controller states
//   - SZ_*            : access size encodings shared with the OTTER memory
//   - IO_BASE_DEFAULT : first address of the memory-mapped IO region
// -----------------------------------------------------------------------------
package otter_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

endpackage

// File: rtl/otter_lsu_merge.sv
// -----------------------------------------------------------------------------
// otter_lsu_merge
// Byte-lane assembly for split (misaligned) loads plus final extension.
//   i_asm    : bytes gathered so far (upper unused lanes are zero)
//   i_idx    : lane the incoming byte belongs to
//   i_byte   : byte just returned by memory
//   i_size   : original request size (half or word for split loads)
//   i_sign   : 1 = unsigned, 0 = signed
//   o_asm    : assembly value with i_byte merged into lane i_idx
//   o_result : o_asm extended to 32 bits for the core
// -----------------------------------------------------------------------------
module otter_lsu_merge
  import otter_lsu_pkg::*;
(
  input  logic [31:0] i_asm,
  input  logic [1:0]  i_idx,
  input  logic [7:0]  i_byte,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_asm,
  output logic [31:0] o_result
);

  logic [31:0] w_asm;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_asm = i_asm;
    w_asm[{i_idx, 3'b000} +: 8] = i_byte;
  end

  assign o_asm = w_asm;

  // Only halves need explicit extension; a split word is already 32 bits and
  // the unused upper lanes of a half are zero from the cleared assembly.
  always_comb begin
    o_result = w_asm;
    if (i_size == SZ_HALF) begin
      o_result = i_sign ? {16'h0000, w_asm[15:0]} : {{16{w_asm[15]}}, w_asm[15:0]};
    end
  end

endmodule

// File: rtl/otter_mem_lsu.sv
// -----------------------------------------------------------------------------
// otter_mem_lsu
// Load/store initiator between the OTTER multicycle core and memory port 2.
// Aligned requests become one memory transaction; misaligned half/word
// requests are split into ascending byte accesses (when SPLIT_EN) and load
// bytes are reassembled. IO-region accesses are always single transactions.
//
// Core side : LSU_START/WE/ADDR/WDATA/SIZE/SIGN in, LSU_BUSY/DONE/RDATA/ERR out
// Memory    : MEM_ADDR2/DIN2/WRITE2/READ2/SIZE/SIGN out, MEM_DOUT2 in
//             (read data valid the cycle after MEM_READ2, sliced by the
//             address/size held on the port)
// -----------------------------------------------------------------------------
module otter_mem_lsu
  import otter_lsu_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LSU_START,
  input  logic        LSU_WE,
  input  logic [31:0] LSU_ADDR,
  input  logic [31:0] LSU_WDATA,
  input  logic [1:0]  LSU_SIZE,
  input  logic        LSU_SIGN,
  output logic        LSU_BUSY,
  output logic        LSU_DONE,
  output logic [31:0] LSU_RDATA,
  output logic        LSU_ERR,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

  lsu_state_t  r_state;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_sign;
  logic        r_split;   // request is being executed as byte accesses
  logic        r_fault;   // request rejected at decode
  logic [1:0]  r_idx;     // current byte index of a split access
  logic [1:0]  r_last;    // index of the final byte of a split access
  logic [31:0] r_asm;
  logic [31:0] r_rdata;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;
  logic        r_mem_write;
  logic        r_mem_read;
  logic [1:0]  r_mem_size;
  logic        r_mem_sign;

  logic        w_misal;
  logic        w_io;
  logic [31:0] w_nb_m1;
  logic [31:0] w_end;
  logic        w_err;
  logic [1:0]  w_idx_nxt;
  logic [31:0] w_asm_nxt;
  logic [31:0] w_final;

  // Request decode, evaluated only when a START is accepted in IDLE.
  assign w_misal = ((LSU_SIZE == SZ_HALF) && LSU_ADDR[0]) ||
                   ((LSU_SIZE == SZ_WORD) && (LSU_ADDR[1:0] != 2'b00));
  assign w_io    = (LSU_ADDR >= IO_BASE);
  assign w_nb_m1 = (LSU_SIZE == SZ_HALF) ? 32'd1 : 32'd3;
  assign w_end   = LSU_ADDR + w_nb_m1;
  // A split must neither start in nor run into the IO region.
  assign w_err   = (LSU_SIZE == SZ_ILLEGAL) ||
                   (w_misal && (w_io || !SPLIT_EN || (w_end >= IO_BASE)));

  assign w_idx_nxt = r_idx + 2'd1;

  otter_lsu_merge u_merge (
    .i_asm    (r_asm),
    .i_idx    (r_idx),
    .i_byte   (MEM_DOUT2[7:0]),
    .i_size   (r_size),
    .i_sign   (r_sign),
    .o_asm    (w_asm_nxt),
    .o_result (w_final)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_size      <= SZ_BYTE;
      r_sign      <= 1'b0;
      r_split     <= 1'b0;
      r_fault     <= 1'b0;
      r_idx       <= '0;
      r_last      <= '0;
      r_asm       <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_size  <= SZ_BYTE;
      r_mem_sign  <= 1'b0;
    end else begin
      // Strobes and the completion pulse are single-cycle unless re-armed.
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (LSU_START) begin
            r_we    <= LSU_WE;
            r_wdata <= LSU_WDATA;
            r_size  <= LSU_SIZE;
            r_sign  <= LSU_SIGN;
            r_split <= w_misal;
            r_fault <= w_err;
            r_idx   <= 2'd0;
            r_last  <= w_nb_m1[1:0];
            r_asm   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
            if (!w_err) begin
              r_mem_addr  <= LSU_ADDR;
              r_mem_read  <= !LSU_WE;
              r_mem_write <= LSU_WE;
              if (w_misal) begin
                // First byte of a split; byte loads come back unsigned.
                r_mem_size <= SZ_BYTE;
                r_mem_sign <= 1'b1;
                r_mem_din  <= {24'h0, LSU_WDATA[7:0]};
              end else begin
                r_mem_size <= LSU_SIZE;
                r_mem_sign <= LSU_SIGN;
                r_mem_din  <= LSU_WDATA;
              end
            end
          end
        end

        ST_ISSUE: begin
          if (r_fault) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else if (!r_we) begin
            r_state <= ST_RDWAIT;
          end else if (!r_split || (r_idx == r_last)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            // Back-to-back byte stores: stay in ISSUE for the next byte.
            r_idx       <= w_idx_nxt;
            r_mem_addr  <= r_mem_addr + 32'd1;
            r_mem_din   <= {24'h0, r_wdata[{w_idx_nxt, 3'b000} +: 8]};
            r_mem_write <= 1'b1;
          end
        end

        ST_RDWAIT: begin
          // MEM_ADDR2/SIZE/SIGN stay put here so the memory slices correctly.
          if (!r_split) begin
            r_rdata <= MEM_DOUT2;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_idx == r_last) begin
            r_rdata <= w_final;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_asm      <= w_asm_nxt;
            r_idx      <= w_idx_nxt;
            r_mem_addr <= r_mem_addr + 32'd1;
            r_mem_read <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign LSU_BUSY   = r_busy;
  assign LSU_DONE   = r_done;
  assign LSU_RDATA  = r_rdata;
  assign LSU_ERR    = r_err;
  assign MEM_ADDR2  = r_mem_addr;
  assign MEM_DIN2   = r_mem_din;
  assign MEM_WRITE2 = r_mem_write;
  assign MEM_READ2  = r_mem_read;
  assign MEM_SIZE   = r_mem_size;
  assign MEM_SIGN   = r_mem_sign;

endmodule

// File: tb/tb_otter_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_otter_mem_lsu
// Drives otter_mem_lsu against a behavioural OTTER data-port memory and
// compares every request with a byte-array reference model: expected load
// values, error flag, completion latency, strobe counts, per-strobe
// address/size/data, and memory contents after stores.
// -----------------------------------------------------------------------------
module tb_otter_mem_lsu;

  localparam logic [31:0] IO_BASE = 32'h1100_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size  = '0;
  logic        sign  = 1'b0;

  logic        busy, done, err;
  logic [31:0] rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_write, mem_read, mem_sign;
  logic [1:0]  mem_size;

  int total = 0;
  int bad   = 0;

  bit [7:0]    mem    [0:4095];   // memory as written by the DUT
  bit [7:0]    shadow [0:4095];   // reference model of the same memory
  bit [31:0]   r_word;
  bit          r_io;
  logic [31:0] io_in       = 32'hC0DE_5A5A;
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  otter_mem_lsu dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .LSU_START  (start),
    .LSU_WE     (we),
    .LSU_ADDR   (addr),
    .LSU_WDATA  (wdata),
    .LSU_SIZE   (size),
    .LSU_SIGN   (sign),
    .LSU_BUSY   (busy),
    .LSU_DONE   (done),
    .LSU_RDATA  (rdata),
    .LSU_ERR    (err),
    .MEM_ADDR2  (mem_addr),
    .MEM_DIN2   (mem_din),
    .MEM_WRITE2 (mem_write),
    .MEM_READ2  (mem_read),
    .MEM_SIZE   (mem_size),
    .MEM_SIGN   (mem_sign),
    .MEM_DOUT2  (mem_dout)
  );

  // Data-port memory: synchronous read of the containing word (or the IO
  // input buffer), byte-lane writes, output sliced by the live address/size.
  always @(posedge clk) begin
    if (mem_read) begin
      r_io   <= (mem_addr >= IO_BASE);
      r_word <= (mem_addr >= IO_BASE) ? io_in :
                {mem[{mem_addr[11:2], 2'd3}], mem[{mem_addr[11:2], 2'd2}],
                 mem[{mem_addr[11:2], 2'd1}], mem[{mem_addr[11:2], 2'd0}]};
    end
    if (mem_write && (mem_addr < IO_BASE)) begin
      mem[mem_addr[11:0]] <= mem_din[7:0];
      if (mem_size != 2'd0) mem[mem_addr[11:0] + 12'd1] <= mem_din[15:8];
      if (mem_size == 2'd2) begin
        mem[mem_addr[11:0] + 12'd2] <= mem_din[23:16];
        mem[mem_addr[11:0] + 12'd3] <= mem_din[31:24];
      end
    end
  end

  logic [31:0] sh;
  always_comb begin
    sh = r_word >> {mem_addr[1:0], 3'b000};
    case (mem_size)
      2'd0:    mem_dout = mem_sign ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    mem_dout = mem_sign ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: mem_dout = r_word;
    endcase
    if (r_io) mem_dout = r_word;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request, predicted from the access rules and checked end to end.
  task automatic do_op(input logic op_we, input logic [31:0] op_addr,
                       input logic [31:0] op_wdata, input logic [1:0] op_size,
                       input logic op_sign, input bit hold);
    int          nb, exp_lat, exp_str, lat, nrd, nwr, ns;
    logic        mis, io, exp_err;
    logic [31:0] v;

    nb      = (op_size == 2'd0) ? 1 : (op_size == 2'd1) ? 2 : 4;
    mis     = ((op_size == 2'd1) && op_addr[0]) || ((op_size == 2'd2) && (op_addr[1:0] != 2'b00));
    io      = (op_addr >= IO_BASE);
    exp_err = (op_size == 2'd3) || (mis && (io || ((op_addr + 32'(nb - 1)) >= IO_BASE)));
    if (exp_err)   exp_lat = 2;
    else if (!mis) exp_lat = op_we ? 2 : 3;
    else           exp_lat = op_we ? nb + 1 : 2 * nb + 1;
    exp_str = exp_err ? 0 : (mis ? nb : 1);

    if (!op_we && !exp_err) begin
      if (io) v = io_in;
      else begin
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = shadow[12'(op_addr + 32'(i))];
        if (op_size == 2'd0)      v = op_sign ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (op_size == 2'd1) v = op_sign ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      end
      model_rdata = v;
    end

    @(negedge clk);
    start = 1'b1; we = op_we; addr = op_addr; wdata = op_wdata; size = op_size; sign = op_sign;
    @(posedge clk);
    lat = 0; nrd = 0; nwr = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (mem_read || mem_write) begin
        ns = nrd + nwr;
        check("strobe_kind", 32'({mem_read, mem_write}), op_we ? 32'd1 : 32'd2);
        check("mem_addr", mem_addr, mis ? op_addr + 32'(ns) : op_addr);
        check("mem_size", 32'(mem_size), mis ? 32'd0 : 32'(op_size));
        if (op_we) check("mem_din", mis ? {24'h0, mem_din[7:0]} : mem_din,
                         mis ? {24'h0, op_wdata[8*ns +: 8]} : op_wdata);
        else       check("mem_sign", 32'(mem_sign), mis ? 32'd1 : 32'(op_sign));
        nrd += int'(mem_read);
        nwr += int'(mem_write);
      end
      if (done) lat = c;
      else      check("busy", 32'(busy), 32'd1);
    end
    start = 1'b0;

    check("latency", 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      check("err", 32'(err), 32'(exp_err));
      check("rdata", rdata, model_rdata);
      check("busy_in_done", 32'(busy), 32'd0);
    end
    check("reads",  32'(nrd), op_we ? 32'd0 : 32'(exp_str));
    check("writes", 32'(nwr), op_we ? 32'(exp_str) : 32'd0);

    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);

    if (op_we && !exp_err && !io) begin
      for (int i = 0; i < nb; i++) begin
        shadow[12'(op_addr + 32'(i))] = op_wdata[8*i +: 8];
        check("mem_byte", 32'(mem[12'(op_addr + 32'(i))]), 32'(shadow[12'(op_addr + 32'(i))]));
      end
    end
  endtask

  initial begin
    int nw;

    // Reset state.
    #12;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_strb",  32'({mem_read, mem_write}), 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_din",   mem_din, 32'd0);
    check("rst_szsg",  32'({mem_size, mem_sign}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload through the LSU, then aligned load.
    do_op(1'b1, 32'h100, 32'h8844_2211, 2'd2, 1'b0, 1'b0);
    do_op(1'b1, 32'h104, 32'h0000_00FF, 2'd2, 1'b0, 1'b0);
    do_op(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0);
    check("lw_aligned_const", rdata, 32'h8844_2211);

    // Byte store inside a word, read back, restore.
    do_op(1'b1, 32'h102, 32'h0000_00AB, 2'd0, 1'b0, 1'b0);
    do_op(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0);
    check("sb_readback_const", rdata, 32'h88AB_2211);
    do_op(1'b1, 32'h102, 32'h0000_0044, 2'd0, 1'b0, 1'b0);

    // Misaligned splits.
    do_op(1'b0, 32'h103, 32'h0, 2'd2, 1'b0, 1'b0);
    check("lw_split_const", rdata, 32'h0000_FF88);
    do_op(1'b0, 32'h103, 32'h0, 2'd1, 1'b0, 1'b0);
    check("lh_split_signed_const", rdata, 32'hFFFF_FF88);
    do_op(1'b0, 32'h103, 32'h0, 2'd1, 1'b1, 1'b0);
    do_op(1'b1, 32'h107, 32'h0000_1234, 2'd1, 1'b0, 1'b0);
    check("sh_split_lo", 32'(mem[12'h107]), 32'h34);
    check("sh_split_hi", 32'(mem[12'h108]), 32'h12);

    // Error cases and IO.
    do_op(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 1'b0);
    do_op(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd3, 1'b0, 1'b0);
    do_op(1'b0, 32'h1100_0002, 32'h0, 2'd2, 1'b0, 1'b0);
    do_op(1'b0, 32'h10FF_FFFE, 32'h0, 2'd2, 1'b0, 1'b0);
    do_op(1'b0, 32'h1100_0000, 32'h0, 2'd2, 1'b0, 1'b0);
    check("io_load_const", rdata, 32'hC0DE_5A5A);

    // START held high through the whole request must not start a second one.
    do_op(1'b0, 32'h105, 32'h0, 2'd2, 1'b1, 1'b1);

    // Reset in the middle of a split store, after two bytes were written.
    @(negedge clk);
    start = 1'b1; we = 1'b1; addr = 32'h301; wdata = 32'hA1B2_C3D4; size = 2'd2; sign = 1'b0;
    @(posedge clk);
    nw = 0;
    for (int c = 0; c < 10 && nw < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_write) nw++;
    end
    check("rst_mid_two_writes", 32'(nw), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_idle", 32'({busy, done, mem_write}), 32'd0);
    end
    shadow[12'h301] = 8'hD4;
    shadow[12'h302] = 8'hC3;
    for (int i = 1; i < 5; i++)
      check("rst_mid_mem", 32'(mem[12'(32'h300 + 32'(i))]), 32'(shadow[12'(32'h300 + 32'(i))]));
    do_op(1'b0, 32'h301, 32'h0, 2'd1, 1'b1, 1'b0);
    check("post_rst_load_const", rdata, 32'h0000_C3D4);

    // Randomized traffic in a small window.
    for (int n = 0; n < 60; n++) begin
      do_op(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 255)), $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_mem_lsu.md
Name: otter_mem_lsu

Overview:
- Load/store initiator between the OTTER multicycle core and port 2 (data port) of the byte-addressable OTTER memory.
- Takes one load or store request from the core and issues it on the memory's data port, honouring the memory's 1-cycle synchronous read latency.
- Memory does not support accesses that span a word boundary, so the LSU splits misaligned half/word accesses into sequential byte accesses and reassembles load data.
- Also routes the IO region (address >= IO_BASE) as single, aligned, word transactions.

Parameters:
IO_BASE, 32'h11000000, first address of the memory-mapped IO region.
SPLIT_EN, 1, 1: misaligned accesses are split into byte ops; 0: misaligned accesses raise LSU_ERR with no memory access.

Ports:
CLK  in  1  core clock (same clock as the memory).
RST_N  in  1  asynchronous active-low reset.
LSU_START  in  1  request strobe, sampled only in IDLE.
LSU_WE  in  1  1 = store, 0 = load.
LSU_ADDR  in  32  byte address.
LSU_WDATA  in  32  store data, right-justified.
LSU_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
LSU_SIGN  in  1  1 = unsigned load (lbu/lhu), 0 = signed (memory's encoding).
LSU_BUSY  out  1  high from the cycle after START is accepted until DONE.
LSU_DONE  out  1  one-cycle completion pulse.
LSU_RDATA  out  32  load result, extended to 32 bits; held until the next accepted START.
LSU_ERR  out  1  valid with DONE; illegal size or illegal misaligned access.
MEM_ADDR2  out  32  data-port address.
MEM_DIN2  out  32  data-port write data.
MEM_WRITE2  out  1  write strobe.
MEM_READ2  out  1  read strobe.
MEM_SIZE  out  2  access size sent to memory.
MEM_SIGN  out  1  sign select sent to memory.
MEM_DOUT2  in  32  memory read data, valid the cycle after MEM_READ2, sliced by current MEM_ADDR2/MEM_SIZE.

Behaviour:
- Reset (async, RST_N = 0): state IDLE. All outputs 0: BUSY, DONE, ERR, RDATA, MEM_WRITE2, MEM_READ2, MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN. Reset mid-operation drops all strobes immediately; no partial completion is reported.
- START acceptance:
  - START is accepted only in IDLE; it is ignored otherwise.
  - On acceptance, the request fields are registered.
  - Decode on acceptance: misaligned = (SIZE == 1 and ADDR[0]) or (SIZE == 2 and ADDR[1:0] != 0); io = ADDR >= IO_BASE.
- Error cases:
  - SIZE == 3, or misaligned with io, or misaligned with SPLIT_EN == 0, or misaligned with ADDR + nbytes - 1 >= IO_BASE.
  - Response: no MEM strobe; go to DONE with ERR = 1; RDATA unchanged.
- States: IDLE, ISSUE, RDWAIT, DONE.
- Aligned access:
  - ISSUE drives MEM_ADDR2 = ADDR, MEM_SIZE = SIZE, MEM_SIGN = SIGN, MEM_DIN2 = WDATA, and MEM_READ2 or MEM_WRITE2 for exactly one cycle.
  - Store: ISSUE -> DONE.
  - Load: ISSUE -> RDWAIT. In RDWAIT, ADDR/SIZE/SIGN are held and MEM_DOUT2 is registered into RDATA; then DONE.
- Latency (START sampled at edge k):
  - Aligned load: READ2 high in cycle k+1, DONE in cycle k+3.
  - Aligned store: WRITE2 high in cycle k+1, DONE in cycle k+2.
- Misaligned split (nbytes = 2 or 4), byte index i = 0..nbytes-1, in ascending order:
  - Each byte access uses MEM_ADDR2 = ADDR + i (32-bit wrap), MEM_SIZE = 0.
  - Stores: MEM_DIN2[7:0] = WDATA[8i+7:8i], one ISSUE cycle per byte, back-to-back; DONE after the last byte.
  - Loads: MEM_SIGN = 1 (unsigned). Each byte takes ISSUE then RDWAIT, capturing MEM_DOUT2[7:0] into byte lane i of an assembly register.
  - After the last byte, RDATA = assembled value, sign-extended from bit 15 for a half with SIGN == 0, zero-extended otherwise.
  - Misaligned load latency: DONE at cycle k + 2*nbytes + 1. Misaligned store latency: DONE at cycle k + nbytes + 1.
- IO region accesses: always exactly one transaction. Memory returns its IO input buffer, captured on READ2.
- DONE: lasts one cycle, then IDLE. START is accepted in IDLE the cycle after DONE at the earliest. BUSY = 0 during DONE.
- MEM_READ2 and MEM_WRITE2 are never high simultaneously and are never high outside ISSUE.

Decomposition:
- Shared package otter_lsu_pkg: state enum, size constants SZ_BYTE/SZ_HALF/SZ_WORD, and the default IO base constant.
- One sub-module, otter_lsu_merge: combinational byte-lane assembly plus sign/zero extension of the final load result.
- FSM and request registers stay in otter_mem_lsu.

Test Plan:
- Memory word 0x100 = 0x8844_2211; aligned LW @0x100 -> READ2 in k+1, DONE in k+3, RDATA = 0x88442211, ERR = 0.
- SB @0x102 with WDATA = 0xAB -> single WRITE2 with MEM_SIZE = 0, DIN2[7:0] = 0xAB; word reads back 0x88AB2211; DONE in k+2.
- Words 0x100 = 0x8844_2211, 0x104 = 0x0000_00FF; LW @0x103 -> four byte reads at 0x103..0x106; RDATA = 0x0000FF88; DONE in k+9.
- LH signed @0x103 with the same data -> RDATA = 0xFFFFFF88; SH @0x107 with WDATA = 0x1234 -> writes 0x34 @0x107 and 0x12 @0x108.
- LSU_SIZE = 3, or LW @0x11000002 -> no MEM strobes, DONE in k+2 with ERR = 1. LW @0x11000000 -> single READ2, RDATA = IO_IN.
- RST_N low in the middle of a split store (after byte 1) -> strobes drop immediately; no DONE; BUSY = 0; next START behaves normally.
